// File: rtl/ifc_pkg.sv
// ifc_pkg: shared types and constants for the ifc command driver.
// Optional timeout logic in the driver is enabled by IFC_DRV_TIMEOUT_EN.
package ifc_pkg;

  localparam int ADDR_W = 3;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam logic [ADDR_W-1:0] DUT_ADDR_CTRL   = 3'd0;
  localparam logic [ADDR_W-1:0] DUT_ADDR_STATUS = 3'd1;
  localparam logic [ADDR_W-1:0] DUT_ADDR_DATA   = 3'd2;
  localparam logic [ADDR_W-1:0] DUT_ADDR_MASK   = 3'd3;
  localparam logic [ADDR_W-1:0] DUT_ADDR_SCRATCH = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic              data;
  } cmd_t;

endpackage

// File: rtl/ifc_cmd_fifo.sv
// ifc_cmd_fifo: power-of-2 command FIFO, extra pointer bit for full/empty.
// Used by ifc_cmd_driver (IFC_DRV_TIMEOUT_EN has no effect here).
module ifc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // pointer advance on accepted push/pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  // pointer and storage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/ifc_cmd_driver.sv
// ifc_cmd_driver: queues write/read commands and drives dut method ports.
// Define IFC_DRV_TIMEOUT_EN to abandon commands whose rdy never rises.
module ifc_cmd_driver
  import ifc_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_data,
  output logic              rsp_err,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic              read_data,
  input  logic              read_rdy
);

  if (TIMEOUT < 1 || TIMEOUT > 65535 || CMD_DEPTH < 2 ||
      (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_param_chk
    $error("ifc_cmd_driver: bad CMD_DEPTH or TIMEOUT");
  end

  state_e            state_q, state_d;
  cmd_t              cur_q, cur_d;
  cmd_t              head;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_data_q, rsp_data_d;
  logic              pop;
  logic              full;
  logic              empty;

`ifdef IFC_DRV_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_err_q, rsp_err_d;
  logic        err_q, err_d;
  logic        rdy;
  assign rdy     = (cur_q.op == OP_READ) ? read_rdy : write_rdy;
  assign rsp_err = rsp_err_q;
  assign err     = err_q;
`else
  assign rsp_err = 1'b0;
  assign err     = 1'b0;
`endif

  ifc_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (cmd_valid),
    .din_i   ({cmd_op, cmd_addr, cmd_data}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign cmd_ready     = !full;
  assign busy          = !empty || (state_q != ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_addr      = rsp_addr_q;
  assign rsp_data      = rsp_data_q;
  assign write_address = cur_q.addr;
  assign write_data    = cur_q.data;
  assign read_address  = cur_q.addr;

  // issue FSM: pop, pulse enable on rdy, hold read response
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    pop        = 1'b0;
    write_en   = 1'b0;
    read_en    = 1'b0;
`ifdef IFC_DRV_TIMEOUT_EN
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = ST_ISSUE;
`ifdef IFC_DRV_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (cur_q.op == OP_WRITE) begin
          write_en = write_rdy;
          if (write_rdy) state_d = ST_IDLE;
        end else begin
          read_en = read_rdy;
          if (read_rdy) begin
            rsp_data_d = read_data;
            rsp_addr_d = cur_q.addr;
            state_d    = ST_RESP;
`ifdef IFC_DRV_TIMEOUT_EN
            rsp_err_d = 1'b0;
`endif
          end
        end
`ifdef IFC_DRV_TIMEOUT_EN
        if (!rdy) begin
          if (cnt_q == TO_LIM) begin
            err_d = 1'b1;
            if (cur_q.op == OP_READ) begin
              rsp_data_d = 1'b0;
              rsp_addr_d = cur_q.addr;
              rsp_err_d  = 1'b1;
              state_d    = ST_RESP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, current-command and response registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef IFC_DRV_TIMEOUT_EN
  // timeout counter and error flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
      err_q     <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_ifc_cmd_driver.sv
// tb_ifc_cmd_driver: directed plus random bench against a memory model.
// Timeout checks run only when IFC_DRV_TIMEOUT_EN is defined.
module tb_ifc_cmd_driver;
  import ifc_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic       cmd_data = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [2:0] rsp_addr;
  logic       rsp_data;
  logic       rsp_err;
  logic       err;
  logic       busy;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy = 1'b0;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy = 1'b0;

  always #5 CLK = ~CLK;

  ifc_cmd_driver #(.CMD_DEPTH(4), .TIMEOUT(8)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_addr      (rsp_addr),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .err           (err),
    .busy          (busy),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  typedef struct packed { logic [2:0] a; logic d; } wr_t;
  typedef struct packed { logic [2:0] a; logic d; logic e; } rd_t;

  int   checks = 0;
  int   failures = 0;
  int   wpulses = 0;
  wr_t  exp_wq[$];
  rd_t  exp_rq[$];
  logic refmem [8];
  logic tbmem [8];
  logic expect_to = 1'b0;

  assign read_data = tbmem[read_address];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push();
    if (cmd_op == OP_WRITE) begin
      refmem[cmd_addr] = cmd_data;
      exp_wq.push_back({cmd_addr, cmd_data});
    end else if (expect_to) begin
      exp_rq.push_back({cmd_addr, 1'b0, 1'b1});
    end else begin
      exp_rq.push_back({cmd_addr, refmem[cmd_addr], 1'b0});
    end
  endtask

  task automatic neg();
    @(negedge CLK);
    if (cmd_valid && cmd_ready) model_push();
  endtask

  task automatic pos();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc();
    neg();
    pos();
  endtask

  task automatic push(input logic op, input logic [2:0] a, input logic d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // waits leave the caller at the negedge where the condition held
  task automatic wait_rsp(input int budget, output int n, output logic f);
    n = 0;
    f = 1'b0;
    while (n < budget) begin
      neg();
      if (rsp_valid) begin f = 1'b1; break; end
      pos();
      n++;
    end
  endtask

  task automatic wait_wen(input int budget, output logic f);
    f = 1'b0;
    for (int n = 0; n < budget; n++) begin
      neg();
      if (write_en) begin f = 1'b1; break; end
      pos();
    end
  endtask

  task automatic wait_idle(input int budget, output logic f);
    f = 1'b0;
    for (int n = 0; n < budget; n++) begin
      neg();
      if (!busy) begin f = 1'b1; break; end
      pos();
    end
  endtask

  // dut emulation and in-order checking of every issued transaction
  initial begin
    wr_t w;
    rd_t r;
    logic bad;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        for (int i = 0; i < 8; i++) tbmem[i] = 1'b0;
      end else begin
        bad = (write_en && read_en) || (write_en && !write_rdy) ||
              (read_en && !read_rdy);
        checks++;
        assert (!bad) else begin
          failures++;
          $error("FAIL proto we=%0b re=%0b wr=%0b rr=%0b",
                 write_en, read_en, write_rdy, read_rdy);
        end
        if (write_en) begin
          wpulses++;
          tbmem[write_address] = write_data;
          checks++;
          if (exp_wq.size() == 0) begin
            failures++;
            $error("FAIL wr_order obs=%0h exp=none",
                   {write_address, write_data});
          end else begin
            w = exp_wq.pop_front();
            assert ({write_address, write_data} === w) else begin
              failures++;
              $error("FAIL wr_order obs=%0h exp=%0h",
                     {write_address, write_data}, w);
            end
          end
        end
        if (rsp_valid && rsp_ready) begin
          checks++;
          if (exp_rq.size() == 0) begin
            failures++;
            $error("FAIL rsp_order obs=%0h exp=none",
                   {rsp_addr, rsp_data, rsp_err});
          end else begin
            r = exp_rq.pop_front();
            assert ({rsp_addr, rsp_data, rsp_err} === r) else begin
              failures++;
              $error("FAIL rsp_order obs=%0h exp=%0h",
                     {rsp_addr, rsp_data, rsp_err}, r);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w0;
    int   n;
    int   acc;
    int   ws;
    int   rs;
    logic f;
    for (int i = 0; i < 8; i++) refmem[i] = 1'b0;

    #12;
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("rst_en", 8'({write_en, read_en}), 8'd0);
    chk("rst_rsp", 8'({rsp_valid, rsp_addr, rsp_data, rsp_err}), 8'd0);
    chk("rst_err_busy", 8'({err, busy}), 8'd0);
    chk("rst_addr", 8'({write_address, write_data, read_address}), 8'd0);
    pos();
    RST_N = 1'b1;

    write_rdy = 1'b1;
    w0 = wpulses;
    push(OP_WRITE, 3'd4, 1'b1);
    neg(); chk("w1_idle_en", 8'(write_en), 8'd0); pos();
    neg();
    chk("w1_en", 8'(write_en), 8'd1);
    chk("w1_addr", 8'(write_address), 8'd4);
    chk("w1_data", 8'(write_data), 8'd1);
    pos();
    neg();
    chk("w1_en_after", 8'(write_en), 8'd0);
    chk("w1_busy", 8'(busy), 8'd0);
    pos();
    chk("w1_pulses", 8'(wpulses - w0), 8'd1);

    write_rdy = 1'b0;
    push(OP_WRITE, 3'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      neg(); chk("w2_hold", 8'(write_en), 8'd0); pos();
    end
    write_rdy = 1'b1;
    neg();
    chk("w2_en", 8'(write_en), 8'd1);
    chk("w2_addr_data", 8'({write_address, write_data}), 8'h0a);
    pos();
    neg(); chk("w2_en_after", 8'(write_en), 8'd0); pos();

    read_rdy  = 1'b1;
    rsp_ready = 1'b0;
    push(OP_WRITE, 3'd3, 1'b1);
    push(OP_READ, 3'd3, 1'b0);
    push(OP_WRITE, 3'd6, 1'b1);
    wait_rsp(20, n, f);
    chk("r_found", 8'(f), 8'd1);
    for (int i = 0; i < 3; i++) begin
      chk("r_valid", 8'(rsp_valid), 8'd1);
      chk("r_addr", 8'(rsp_addr), 8'd3);
      chk("r_data", 8'(rsp_data), 8'd1);
      chk("r_wr_blocked", 8'(write_en), 8'd0);
      pos();
      neg();
    end
    pos();
    rsp_ready = 1'b1;
    neg();
    chk("r_valid_hs", 8'(rsp_valid), 8'd1);
    chk("r_wr_blocked_hs", 8'(write_en), 8'd0);
    pos();
    rsp_ready = 1'b0;
    wait_wen(20, f);
    chk("r_next_wr", 8'(f), 8'd1);
    chk("r_next_wr_addr", 8'(write_address), 8'd6);
    pos();

    write_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      cmd_addr  = 3'(i);
      cmd_data  = 1'($urandom_range(0, 1));
      neg();
      if (cmd_ready) acc++;
      pos();
    end
    cmd_valid = 1'b0;
    chk("full_acc", 8'(acc), 8'd5);
    chk("full_ready", 8'(cmd_ready), 8'd0);
    write_rdy = 1'b1;
    w0 = wpulses;
    wait_idle(40, f);
    chk("full_drain", 8'(f), 8'd1);
    pos();
    chk("full_pulses", 8'(wpulses - w0), 8'd5);

`ifdef IFC_DRV_TIMEOUT_EN
    read_rdy  = 1'b0;
    expect_to = 1'b1;
    push(OP_READ, 3'd2, 1'b0);
    expect_to = 1'b0;
    wait_rsp(30, n, f);
    chk("to_found", 8'(f), 8'd1);
    chk("to_cycles", 8'(n), 8'd9);
    chk("to_rsp_err", 8'(rsp_err), 8'd1);
    chk("to_err", 8'(err), 8'd1);
    chk("to_rsp_fields", 8'({rsp_addr, rsp_data}), 8'h04);
    pos();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    read_rdy  = 1'b1;
    write_rdy = 1'b1;
    push(OP_WRITE, 3'd1, 1'b1);
    wait_idle(20, f);
    chk("to_idle", 8'(f), 8'd1);
    chk("to_err_sticky", 8'(err), 8'd1);
    pos();
`endif

    write_rdy = 1'b0;
    push(OP_WRITE, 3'd7, 1'b1);
    cyc();
    cyc();
    write_rdy = 1'b1;
    #1;
    chk("mr_en_pre", 8'(write_en), 8'd1);
    RST_N = 1'b0;
    #1;
    chk("mr_en", 8'(write_en), 8'd0);
    chk("mr_busy", 8'(busy), 8'd0);
    chk("mr_ready", 8'(cmd_ready), 8'd1);
    chk("mr_addr", 8'(write_address), 8'd0);
    exp_wq.delete();
    exp_rq.delete();
    for (int i = 0; i < 8; i++) refmem[i] = 1'b0;
    write_rdy = 1'b0;
    cyc();
    cyc();
    RST_N = 1'b1;

    ws = 0;
    rs = 0;
    for (int c = 0; c < 400; c++) begin
      write_rdy = ($urandom_range(0, 3) != 0) || (ws >= 3);
      read_rdy  = ($urandom_range(0, 3) != 0) || (rs >= 3);
      ws = write_rdy ? 0 : ws + 1;
      rs = read_rdy ? 0 : rs + 1;
      rsp_ready = 1'($urandom_range(0, 1));
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      cmd_addr  = 3'($urandom_range(0, 7));
      cmd_data  = 1'($urandom_range(0, 1));
      cyc();
    end
    cmd_valid = 1'b0;
    write_rdy = 1'b1;
    read_rdy  = 1'b1;
    rsp_ready = 1'b1;
    wait_idle(80, f);
    chk("rnd_drain", 8'(f), 8'd1);
    pos();
    chk("rnd_wq_empty", 8'(exp_wq.size()), 8'd0);
    chk("rnd_rq_empty", 8'(exp_rq.size()), 8'd0);
`ifndef IFC_DRV_TIMEOUT_EN
    chk("no_to_err", 8'({err, rsp_err}), 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
